// File: rtl/vmask_scan.sv
// Mask-scan unit: reduces a streamed mask register to vcpop.m / vfirst.m results.
// Three register stages: active-bit capture, per-beat reduction, accumulate/emit FSM.
module vmask_scan #(
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int IDX_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_start,
    input  logic                       in_end,
    input  logic                       in_op,
    input  logic [RESP_DATA_WIDTH-1:0] in_vec,
    input  logic [RESP_DATA_WIDTH-1:0] in_mask,
    input  logic [IDX_WIDTH-1:0]       in_start_idx,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic                       out_valid
);
    localparam int LW = $clog2(RESP_DATA_WIDTH);
    localparam int PW = LW + 1;
    localparam int CW = IDX_WIDTH + 1;

    // state  | meaning
    // IDLE   | no operation open; non-start beats are dropped
    // ACCUM  | operation open; beats fold into the accumulators
    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    logic [RESP_DATA_WIDTH-1:0] w_act;
    logic [RESP_DATA_WIDTH-1:0] r_s0_act;
    logic [IDX_WIDTH-1:0]       r_s0_idx;
    logic [REQ_ADDR_WIDTH-1:0]  r_s0_addr;
    logic                       r_s0_start, r_s0_end, r_s0_op, r_s0_valid;

    logic [PW-1:0]              w_pop;
    logic [LW-1:0]              w_lsb;
    logic [IDX_WIDTH-1:0]       w_first;
    logic [PW-1:0]              r_s1_pop;
    logic                       r_s1_hit;
    logic [IDX_WIDTH-1:0]       r_s1_first;
    logic [REQ_ADDR_WIDTH-1:0]  r_s1_addr;
    logic                       r_s1_start, r_s1_end, r_s1_op, r_s1_valid;

    state_t                     r_state, w_state_nxt;
    logic [CW-1:0]              r_acc_cnt, w_cnt_nxt;
    logic [CW:0]                w_sum;
    logic                       r_found, w_found_nxt;
    logic [IDX_WIDTH-1:0]       r_first_idx, w_first_nxt;
    logic                       r_op, w_op_nxt;
    logic                       w_emit;
    logic [RESP_DATA_WIDTH-1:0] w_result;

    assign w_act = in_vec & in_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_act   <= '0;
            r_s0_idx   <= '0;
            r_s0_addr  <= '0;
            r_s0_start <= 1'b0;
            r_s0_end   <= 1'b0;
            r_s0_op    <= 1'b0;
            r_s0_valid <= 1'b0;
        end else begin
            r_s0_act   <= w_act & {RESP_DATA_WIDTH{in_valid}};
            r_s0_idx   <= in_start_idx & {IDX_WIDTH{in_valid}};
            r_s0_addr  <= in_addr & {REQ_ADDR_WIDTH{in_valid}};
            r_s0_start <= in_start & in_valid;
            r_s0_end   <= in_end & in_valid;
            r_s0_op    <= in_op & in_valid;
            r_s0_valid <= in_valid;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < RESP_DATA_WIDTH; i++) begin
            w_pop = w_pop + PW'(r_s0_act[i]);
        end
    end

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        w_lsb = '0;
        for (int i = RESP_DATA_WIDTH - 1; i >= 0; i--) begin
            if (r_s0_act[i]) w_lsb = LW'(i);
        end
    end

    assign w_first = r_s0_idx + IDX_WIDTH'(w_lsb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_pop   <= '0;
            r_s1_hit   <= 1'b0;
            r_s1_first <= '0;
            r_s1_addr  <= '0;
            r_s1_start <= 1'b0;
            r_s1_end   <= 1'b0;
            r_s1_op    <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_pop   <= w_pop;
            r_s1_hit   <= |r_s0_act;
            r_s1_first <= w_first;
            r_s1_addr  <= r_s0_addr;
            r_s1_start <= r_s0_start;
            r_s1_end   <= r_s0_end;
            r_s1_op    <= r_s0_op;
            r_s1_valid <= r_s0_valid;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_acc_cnt;
        w_found_nxt = r_found;
        w_first_nxt = r_first_idx;
        w_op_nxt    = r_op;
        w_emit      = 1'b0;
        w_sum       = {1'b0, r_acc_cnt} + (CW+1)'(r_s1_pop);
        if (r_s1_valid) begin
            if (r_s1_start) begin
                w_cnt_nxt   = CW'(r_s1_pop);
                w_found_nxt = r_s1_hit;
                w_first_nxt = r_s1_first;
                w_op_nxt    = r_s1_op;
                w_emit      = r_s1_end;
                w_state_nxt = r_s1_end ? S_IDLE : S_ACCUM;
            end else if (r_state == S_ACCUM) begin
                w_cnt_nxt = w_sum[CW] ? '1 : w_sum[CW-1:0];
                if (!r_found && r_s1_hit) begin
                    w_found_nxt = 1'b1;
                    w_first_nxt = r_s1_first;
                end
                if (r_s1_end) begin
                    w_emit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        end
        if (!w_op_nxt)        w_result = RESP_DATA_WIDTH'(w_cnt_nxt);
        else if (w_found_nxt) w_result = RESP_DATA_WIDTH'(w_first_nxt);
        else                  w_result = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc_cnt   <= '0;
            r_found     <= 1'b0;
            r_first_idx <= '0;
            r_op        <= 1'b0;
            out_valid   <= 1'b0;
            out_vec     <= '0;
            out_addr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc_cnt   <= w_cnt_nxt;
            r_found     <= w_found_nxt;
            r_first_idx <= w_first_nxt;
            r_op        <= w_op_nxt;
            out_valid   <= w_emit;
            if (w_emit) begin
                out_vec  <= w_result;
                out_addr <= r_s1_addr;
            end
        end
    end
endmodule

// File: tb/tb_vmask_scan.sv
// Bench for vmask_scan: directed vector table, corner sequences, and random beats
// scored cycle-by-cycle against a beat-level reference model.
module tb_vmask_scan;
    localparam int CMAX = 131071;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_start = 1'b0, in_end = 1'b0, in_op = 1'b0;
    logic [63:0] in_vec = '0, in_mask = '0;
    logic [15:0] in_start_idx = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] out_addr;
    logic [63:0] out_vec;
    logic        out_valid;

    int tests = 0;
    int fails = 0;

    vmask_scan dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
        .in_op(in_op), .in_vec(in_vec), .in_mask(in_mask), .in_start_idx(in_start_idx),
        .in_addr(in_addr), .out_addr(out_addr), .out_vec(out_vec), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: per-operation running count / first index, results scheduled by edge.
    typedef struct {int due; logic [63:0] v; logic [31:0] a;} exp_t;
    exp_t        pend[$];
    logic [63:0] obs_v[$];
    logic [31:0] obs_a[$];
    int          edge_n = 0;
    bit          started = 0;
    bit          m_active = 0;
    bit          m_op;
    int          m_cnt, m_first;
    logic [63:0] m_last_vec;
    logic [31:0] m_last_addr;

    task automatic model_beat();
        logic [63:0] a;
        exp_t e;
        if (in_start) begin
            m_active = 1; m_op = in_op; m_cnt = 0; m_first = -1;
        end
        if (!m_active) return;
        a = in_vec & in_mask;
        m_cnt = m_cnt + $countones(a);
        if (m_cnt > CMAX) m_cnt = CMAX;
        if (m_first < 0) begin
            for (int i = 0; i < 64; i++) begin
                if (a[i]) begin
                    m_first = (int'(in_start_idx) + i) % 65536;
                    break;
                end
            end
        end
        if (in_end) begin
            e.due = edge_n + 2;
            e.a   = in_addr;
            if (!m_op)           e.v = 64'(m_cnt);
            else if (m_first < 0) e.v = '1;
            else                 e.v = 64'(m_first);
            pend.push_back(e);
            m_active = 0;
        end
    endtask

    always @(posedge clk) begin
        bit ev;
        edge_n++;
        if (rst) begin
            pend.delete();
            m_active = 0;
            started = 1;
            m_last_vec = '0;
            m_last_addr = '0;
        end else if (in_valid) begin
            model_beat();
        end
        #1;
        if (started) begin
            ev = (pend.size() > 0) && (pend[0].due == edge_n);
            if (ev) begin
                m_last_vec  = pend[0].v;
                m_last_addr = pend[0].a;
                void'(pend.pop_front());
            end
            chk("sb_valid", 64'(out_valid), 64'(ev));
            chk("sb_vec", out_vec, m_last_vec);
            chk("sb_addr", 64'(out_addr), 64'(m_last_addr));
            if (out_valid) begin
                obs_v.push_back(out_vec);
                obs_a.push_back(out_addr);
            end
        end
    end

    task automatic beat(input logic st, input logic en, input logic op, input logic [63:0] v,
                        input logic [63:0] m, input logic [15:0] idx, input logic [31:0] a);
        @(negedge clk);
        in_valid = 1'b1; in_start = st; in_end = en; in_op = op;
        in_vec = v; in_mask = m; in_start_idx = idx; in_addr = a;
    endtask

    // Bubbles carry junk on every field so that only in_valid qualifies a beat.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_start = 1'($urandom); in_end = 1'($urandom); in_op = 1'($urandom);
            in_vec = {$urandom, $urandom}; in_mask = {$urandom, $urandom};
            in_start_idx = 16'($urandom); in_addr = $urandom;
        end
    endtask

    task automatic clear_obs();
        obs_v.delete();
        obs_a.delete();
    endtask

    typedef struct {
        logic op; logic [63:0] v; logic [63:0] m; logic [15:0] idx; logic [31:0] a; logic [63:0] exp;
    } vec_t;
    vec_t tbl[8];

    localparam logic [63:0] ONES = '1;

    initial begin
        tbl[0] = '{1'b0, 64'hFF, 64'h0F, 16'd0, 32'h40, 64'd4};
        tbl[1] = '{1'b1, 64'h100, ONES, 16'd0, 32'h44, 64'd8};
        tbl[2] = '{1'b1, 64'hF0, 64'h0F, 16'd0, 32'h48, ONES};
        tbl[3] = '{1'b1, 64'h8000_0000_0000_0000, ONES, 16'hFFF0, 32'h4C, 64'h2F};
        tbl[4] = '{1'b0, ONES, ONES, 16'd0, 32'h50, 64'd64};
        tbl[5] = '{1'b0, 64'h0, ONES, 16'd0, 32'h54, 64'd0};
        tbl[6] = '{1'b1, ONES, 64'h0, 16'd0, 32'h58, ONES};
        tbl[7] = '{1'b1, ONES, ONES, 16'd100, 32'h5C, 64'd100};

        rst = 1'b1;
        idle(3);
        @(negedge clk) rst = 1'b0;
        chk("rst_vec", out_vec, 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            clear_obs();
            beat(1, 1, tbl[i].op, tbl[i].v, tbl[i].m, tbl[i].idx, tbl[i].a);
            idle(4);
            chk($sformatf("tbl%0d_count", i), 64'(obs_v.size()), 64'd1);
            chk($sformatf("tbl%0d_vec", i), obs_v[0], tbl[i].exp);
            chk($sformatf("tbl%0d_addr", i), 64'(obs_a[0]), 64'(tbl[i].a));
        end

        clear_obs();
        beat(1, 0, 1, 64'h0, ONES, 16'd0, 32'h60);
        idle(1);
        beat(0, 1, 0, 64'h8, ONES, 16'd64, 32'h64);
        idle(4);
        chk("bubble_count", 64'(obs_v.size()), 64'd1);
        chk("bubble_vec", obs_v[0], 64'd67);
        chk("bubble_addr", 64'(obs_a[0]), 64'h64);

        clear_obs();
        beat(1, 0, 0, ONES, ONES, 16'd0, 32'h70);
        beat(0, 0, 1, ONES, ONES, 16'd64, 32'h70);
        beat(0, 1, 1, ONES, ONES, 16'd128, 32'h74);
        idle(4);
        chk("pop3_count", 64'(obs_v.size()), 64'd1);
        chk("pop3_vec", obs_v[0], 64'd192);

        clear_obs();
        beat(1, 1, 0, 64'h1F, ONES, 16'd0, 32'h80);
        beat(1, 1, 1, 64'h4, ONES, 16'd0, 32'h84);
        idle(4);
        chk("b2b_count", 64'(obs_v.size()), 64'd2);
        chk("b2b_vec0", obs_v[0], 64'd5);
        chk("b2b_addr0", 64'(obs_a[0]), 64'h80);
        chk("b2b_vec1", obs_v[1], 64'd2);
        chk("b2b_addr1", 64'(obs_a[1]), 64'h84);

        clear_obs();
        beat(1, 0, 0, ONES, ONES, 16'd0, 32'h90);
        beat(1, 0, 1, 64'h2, ONES, 16'd0, 32'h94);
        beat(0, 1, 0, 64'h0, ONES, 16'd64, 32'h98);
        idle(4);
        chk("abort_count", 64'(obs_v.size()), 64'd1);
        chk("abort_vec", obs_v[0], 64'd1);
        chk("abort_addr", 64'(obs_a[0]), 64'h98);

        clear_obs();
        beat(1, 0, 0, ONES, ONES, 16'd0, 32'hA0);
        beat(0, 0, 0, ONES, ONES, 16'd64, 32'hA0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_start = 1'b0; in_end = 1'b1; in_addr = 32'hA4;
        @(negedge clk);
        rst = 1'b0;
        beat(0, 1, 0, ONES, ONES, 16'd128, 32'hA8);
        idle(4);
        chk("rstmid_count", 64'(obs_v.size()), 64'd0);
        chk("rstmid_vec", out_vec, 64'd0);
        chk("rstmid_addr", 64'(out_addr), 64'd0);
        chk("rstmid_valid", 64'(out_valid), 64'd0);

        clear_obs();
        beat(1, 0, 0, ONES, ONES, 16'd0, 32'hB0);
        for (int i = 0; i < 2048; i++) beat(0, 0, 0, ONES, ONES, 16'(i * 64), 32'hB0);
        beat(0, 1, 0, ONES, ONES, 16'd0, 32'hB4);
        idle(4);
        chk("sat_count", 64'(obs_v.size()), 64'd1);
        chk("sat_vec", obs_v[0], 64'(CMAX));

        for (int n = 0; n < 600; n++) begin
            logic [63:0] v, m;
            case ($urandom_range(0, 3))
                0: v = '0;
                1: v = 64'd1 << $urandom_range(0, 63);
                default: v = {$urandom, $urandom};
            endcase
            m = ($urandom_range(0, 1) == 0) ? ONES : {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                rst = 1'b1; in_valid = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if ($urandom_range(0, 9) < 7) begin
                beat(1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 25),
                     1'($urandom), v, m, 16'($urandom), $urandom);
            end else begin
                idle(1);
            end
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
